// File: rtl/pool_pkg.sv
// Shared types and elaboration-time helpers for the max-pooling window sequencer.
package pool_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } pool_state_t;

  function automatic int out_dim(input int row, input int k, input int stride);
    return (row - k) / stride + 1;
  endfunction

  function automatic bit params_legal(input int row, input int k, input int stride);
    return (k >= 1) && (k <= row) && (stride >= 1);
  endfunction

endpackage

// File: rtl/pool_pos_counter.sv
// Raster position tracker: row/col counters, stride phase counters, output-grid
// coordinates and the is_sample / is_last flags for the pixel currently offered.
module pool_pos_counter
  import pool_pkg::*;
#(
  parameter int ROW_SIZE   = 5,
  parameter int KERNEL_DIM = 3,
  parameter int STRIDE     = 1,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          is_sample,
  output logic          is_last
);

  localparam int KM1  = KERNEL_DIM - 1;
  localparam int LAST = ROW_SIZE - 1;

  logic [CW-1:0] row, col, row_ph, col_ph, orow, ocol;
  logic          row_in_win, col_in_win, row_ph_top, col_ph_top, col_wrap;

  assign row_in_win = int'(row) >= KM1;
  assign col_in_win = int'(col) >= KM1;
  assign row_ph_top = int'(row_ph) == STRIDE - 1;
  assign col_ph_top = int'(col_ph) == STRIDE - 1;
  assign col_wrap   = int'(col) == LAST;

  // Phases only start counting once the window is fully inside the frame, so
  // phase==0 there means (pos - KERNEL_DIM + 1) % STRIDE == 0.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset lives inside the clocked block; only registers
    // whose reset value is observable are listed, and all of them are here.
    if (rst || clear) begin
      row    <= '0;
      col    <= '0;
      row_ph <= '0;
      col_ph <= '0;
      orow   <= '0;
      ocol   <= '0;
    end else if (advance) begin
      if (col_wrap) begin
        col    <= '0;
        col_ph <= '0;
        ocol   <= '0;
        row    <= row + CW'(1);
        if (row_in_win) begin
          if (row_ph_top) begin
            row_ph <= '0;
            orow   <= orow + CW'(1);
          end else begin
            row_ph <= row_ph + CW'(1);
          end
        end
      end else begin
        col <= col + CW'(1);
        if (col_in_win) begin
          if (col_ph_top) begin
            col_ph <= '0;
            ocol   <= ocol + CW'(1);
          end else begin
            col_ph <= col_ph + CW'(1);
          end
        end
      end
    end
  end

  assign out_row   = orow;
  assign out_col   = ocol;
  assign is_sample = row_in_win && col_in_win && (row_ph == '0) && (col_ph == '0);
  assign is_last   = (int'(row) == LAST) && col_wrap;

endmodule

// File: rtl/pool_window_ctrl.sv
// Frame sequencer for the max-pooling sliding window: handshakes the pixel
// stream, strobes the window, and holds each legal pooling position until consumed.
module pool_window_ctrl
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 3,
  parameter int ROW_SIZE   = 5,
  parameter int STRIDE     = 1,
  localparam int OUT_DIM   = out_dim(ROW_SIZE, KERNEL_DIM, STRIDE),
  localparam int CW        = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  output logic                  win_clear,
  output logic                  win_shift,
  output logic [DATA_WIDTH-1:0] win_pixel,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic [CW-1:0]         out_row,
  output logic [CW-1:0]         out_col
);

  if (!params_legal(ROW_SIZE, KERNEL_DIM, STRIDE) || OUT_DIM < 1) begin : g_param_check
    $error("pool_window_ctrl: illegal ROW_SIZE/KERNEL_DIM/STRIDE combination");
  end

  pool_state_t   state, state_nxt;
  logic          stream, accept, is_sample, is_last;
  logic [CW-1:0] pos_row, pos_col;

  pool_pos_counter #(
    .ROW_SIZE  (ROW_SIZE),
    .KERNEL_DIM(KERNEL_DIM),
    .STRIDE    (STRIDE),
    .CW        (CW)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .clear    (win_clear),
    .advance  (accept),
    .out_row  (pos_row),
    .out_col  (pos_col),
    .is_sample(is_sample),
    .is_last  (is_last)
  );

  // A held sample blocks input so the window cannot move under an unconsumed result.
  assign stream    = (state == ST_STREAM);
  assign in_ready  = stream && (!sample_valid || sample_ready);
  assign accept    = in_valid && in_ready;
  assign win_shift = accept;
  assign win_pixel = in_pixel;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    win_clear = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        win_clear = 1'b1;
        state_nxt = ST_STREAM;
      end
      ST_STREAM: if (accept && is_last) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!sample_valid || sample_ready) state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_valid <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
    end else if (accept && is_sample) begin
      sample_valid <= 1'b1;
      out_row      <= pos_row;
      out_col      <= pos_col;
    end else if (sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Self-checking bench for pool_window_ctrl: three parameterisations, table-driven
// frames, reset corner cases and randomized handshakes against a behavioural model.
module tb_pool_window_ctrl;

  localparam int NDUT = 3;
  localparam int KD   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NDUT-1:0] start_v, in_valid_v, sample_ready_v;
  logic [NDUT-1:0] busy_v, done_v, in_ready_v, win_clear_v, win_shift_v, sample_valid_v;
  logic [7:0]      in_pixel_a  [NDUT];
  logic [7:0]      win_pixel_a [NDUT];
  logic [2:0]      out_row_a   [NDUT];
  logic [2:0]      out_col_a   [NDUT];

  // dut0: 5x5 stride 1, dut1: 5x5 stride 2, dut2: 6x6 stride 2 (all kernel 3)
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    pool_window_ctrl #(
      .DATA_WIDTH(8),
      .KERNEL_DIM(KD),
      .ROW_SIZE  ((g == 2) ? 6 : 5),
      .STRIDE    ((g == 0) ? 1 : 2)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start_v[g]),
      .busy        (busy_v[g]),
      .done        (done_v[g]),
      .in_valid    (in_valid_v[g]),
      .in_ready    (in_ready_v[g]),
      .in_pixel    (in_pixel_a[g]),
      .win_clear   (win_clear_v[g]),
      .win_shift   (win_shift_v[g]),
      .win_pixel   (win_pixel_a[g]),
      .sample_valid(sample_valid_v[g]),
      .sample_ready(sample_ready_v[g]),
      .out_row     (out_row_a[g]),
      .out_col     (out_col_a[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cfg_r(input int d);
    return (d == 2) ? 6 : 5;
  endfunction

  function automatic int cfg_s(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic bit pos_is_sample(input int d, input int p);
    int r, c, s;
    r = p / cfg_r(d);
    c = p % cfg_r(d);
    s = cfg_s(d);
    return (r >= KD - 1) && (c >= KD - 1) && ((r - KD + 1) % s == 0) && ((c - KD + 1) % s == 0);
  endfunction

  // Observed from the DUT during the last frame
  int obs_pix[$], obs_row[$], obs_col[$];
  int done_lat;
  // Expected lists for comparison
  int exp_pix[$], exp_row[$], exp_col[$];

  typedef struct {
    int dut;
    int vmode;   // 0 always valid, 1 toggling, 2 random
    int rmode;   // 0 always ready, 1 stall 3 cycles at first sample, 2 random
    bit mid_start;
    int n;
    int pix[9];
    int orow[9];
    int ocol[9];
  } vec_t;

  vec_t tbl[5];

  task automatic build_expected(input int d);
    int r_sz;
    r_sz = cfg_r(d);
    exp_pix.delete(); exp_row.delete(); exp_col.delete();
    for (int p = 0; p < r_sz * r_sz; p++) begin
      if (pos_is_sample(d, p)) begin
        exp_pix.push_back(p + 1);
        exp_row.push_back((p / r_sz - KD + 1) / cfg_s(d));
        exp_col.push_back((p % r_sz - KD + 1) / cfg_s(d));
      end
    end
  endtask

  task automatic compare_lists(input string tag);
    check({tag, " sample_count"}, obs_pix.size(), exp_pix.size());
    check({tag, " consumed_count"}, obs_row.size(), exp_row.size());
    for (int i = 0; i < exp_pix.size(); i++) begin
      if (i < obs_pix.size()) check({tag, " sample_pixel"}, obs_pix[i], exp_pix[i]);
      if (i < obs_row.size()) begin
        check({tag, " out_row"}, obs_row[i], exp_row[i]);
        check({tag, " out_col"}, obs_col[i], exp_col[i]);
      end
    end
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, " busy"}, busy_v[d], 0);
    check({tag, " done"}, done_v[d], 0);
    check({tag, " in_ready"}, in_ready_v[d], 0);
    check({tag, " win_clear"}, win_clear_v[d], 0);
    check({tag, " win_shift"}, win_shift_v[d], 0);
    check({tag, " sample_valid"}, sample_valid_v[d], 0);
    check({tag, " out_row"}, out_row_a[d], 0);
    check({tag, " out_col"}, out_col_a[d], 0);
    check({tag, " win_pixel"}, win_pixel_a[d], in_pixel_a[d]);
  endtask

  task automatic run_frame(input int d, input int vmode, input int rmode, input bit mid_start);
    int  r_sz, s, p, cyc, last_acc_cyc, done_cyc, stall, rr, cc;
    bit  exp_sv, streaming, draining, done_due, stall_used, release_chk;
    bit  v, ready, exp_rdy, hs, acc, prev_acc, prev_sv, prev_hs;
    int  exp_or, exp_oc, prev_pix;
    r_sz = cfg_r(d); s = cfg_s(d);
    p = 0; cyc = 0; last_acc_cyc = -1; done_cyc = -1; stall = 0;
    exp_sv = 0; streaming = 1; draining = 0; done_due = 0; stall_used = 0; release_chk = 0;
    exp_or = 0; exp_oc = 0; prev_acc = 0; prev_sv = 0; prev_hs = 0; prev_pix = 0;
    obs_pix.delete(); obs_row.delete(); obs_col.delete();

    @(posedge clk); #1;
    start_v[d] = 1'b1; in_valid_v[d] = 1'b1; in_pixel_a[d] = 8'd1; sample_ready_v[d] = 1'b1;
    @(negedge clk);
    check("idle busy before start edge", busy_v[d], 0);
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    @(negedge clk);
    check("clear win_clear", win_clear_v[d], 1);
    check("clear busy", busy_v[d], 1);
    check("clear in_ready", in_ready_v[d], 0);
    check("clear win_shift", win_shift_v[d], 0);

    while (cyc < 1000) begin
      @(posedge clk); #1;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      case (rmode)
        0: ready = 1'b1;
        1: begin
          ready = 1'b1;
          if (exp_sv && !stall_used) begin
            if (stall < 3) begin
              ready = 1'b0;
              stall++;
            end else begin
              stall_used  = 1'b1;
              release_chk = 1'b1;
            end
          end
        end
        default: ready = 1'($urandom_range(0, 1));
      endcase
      in_valid_v[d]     = v;
      in_pixel_a[d]     = 8'(p + 1);
      sample_ready_v[d] = ready;
      start_v[d]        = mid_start && (p == 7);
      @(negedge clk);
      cyc++;

      exp_rdy = streaming && (!exp_sv || ready);
      hs      = exp_sv && ready;
      acc     = v && exp_rdy;
      check("in_ready", in_ready_v[d], exp_rdy);
      check("win_shift", win_shift_v[d], acc);
      check("win_pixel", win_pixel_a[d], 8'(p + 1));
      check("sample_valid", sample_valid_v[d], exp_sv);
      if (exp_sv) begin
        check("held out_row", out_row_a[d], exp_or);
        check("held out_col", out_col_a[d], exp_oc);
      end
      check("done", done_v[d], done_due);
      check("busy", busy_v[d], 1);
      check("win_clear in frame", win_clear_v[d], 0);
      if (release_chk) begin
        check("release accept", win_shift_v[d], 1);
        check("release pixel", win_pixel_a[d], 14);
        release_chk = 1'b0;
      end

      if (sample_valid_v[d] && prev_acc && (!prev_sv || prev_hs)) obs_pix.push_back(prev_pix);
      if (sample_valid_v[d] && sample_ready_v[d]) begin
        obs_row.push_back(int'(out_row_a[d]));
        obs_col.push_back(int'(out_col_a[d]));
      end
      prev_acc = win_shift_v[d];
      prev_pix = int'(win_pixel_a[d]);
      prev_sv  = sample_valid_v[d];
      prev_hs  = sample_valid_v[d] && ready;

      if (done_due) begin
        done_cyc = cyc;
        break;
      end
      if (draining && hs) done_due = 1'b1;
      if (draining && !exp_sv) done_due = 1'b1;
      if (acc) begin
        rr = p / r_sz;
        cc = p % r_sz;
        if (pos_is_sample(d, p)) begin
          exp_sv = 1'b1;
          exp_or = (rr - KD + 1) / s;
          exp_oc = (cc - KD + 1) / s;
        end else if (hs) begin
          exp_sv = 1'b0;
        end
        p++;
        if (p == r_sz * r_sz) begin
          streaming    = 1'b0;
          draining     = 1'b1;
          last_acc_cyc = cyc;
        end
      end else if (hs) begin
        exp_sv = 1'b0;
      end
    end

    if (done_cyc < 0) check("done timeout", 0, 1);
    done_lat = done_cyc - last_acc_cyc;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    start_v[d]    = 1'b0;
    @(negedge clk);
    check("after done pulse", done_v[d], 0);
    check("after done busy", busy_v[d], 0);
  endtask

  task automatic reset_mid(input int d, input int npix);
    @(posedge clk); #1;
    start_v[d] = 1'b1; in_valid_v[d] = 1'b1; sample_ready_v[d] = 1'b1; in_pixel_a[d] = 8'd1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    for (int i = 0; i < npix; i++) begin
      @(posedge clk); #1;
      in_pixel_a[d] = 8'(i + 1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    in_pixel_a[d] = 8'(npix + 1);
    @(negedge clk);
    check("pre-reset busy", busy_v[d], 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs(d, "mid-frame reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no completion after reset", done_v[d], 0);
    end
    in_valid_v[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_v = '0; in_valid_v = '0; sample_ready_v = '0;
    for (int d = 0; d < NDUT; d++) in_pixel_a[d] = 8'hA5;

    tbl[0].dut = 0; tbl[0].vmode = 0; tbl[0].rmode = 0; tbl[0].mid_start = 0; tbl[0].n = 9;
    tbl[0].pix  = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
    tbl[0].orow = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    tbl[0].ocol = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    tbl[1].dut = 1; tbl[1].vmode = 0; tbl[1].rmode = 0; tbl[1].mid_start = 0; tbl[1].n = 4;
    tbl[1].pix  = '{13, 15, 23, 25, 0, 0, 0, 0, 0};
    tbl[1].orow = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[1].ocol = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[2].dut = 2; tbl[2].vmode = 0; tbl[2].rmode = 0; tbl[2].mid_start = 0; tbl[2].n = 4;
    tbl[2].pix  = '{15, 17, 27, 29, 0, 0, 0, 0, 0};
    tbl[2].orow = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[2].ocol = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[3] = tbl[0]; tbl[3].rmode = 1;
    tbl[4] = tbl[0]; tbl[4].vmode = 1; tbl[4].mid_start = 1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check_reset_outputs(d, "power-on reset");

    reset_mid(0, 10);

    for (int t = 0; t < 5; t++) begin
      run_frame(tbl[t].dut, tbl[t].vmode, tbl[t].rmode, tbl[t].mid_start);
      exp_pix.delete(); exp_row.delete(); exp_col.delete();
      for (int i = 0; i < tbl[t].n; i++) begin
        exp_pix.push_back(tbl[t].pix[i]);
        exp_row.push_back(tbl[t].orow[i]);
        exp_col.push_back(tbl[t].ocol[i]);
      end
      compare_lists($sformatf("table[%0d]", t));
      check($sformatf("table[%0d] done latency", t), done_lat, 2);
    end

    reset_mid(0, 19);
    run_frame(0, 0, 0, 1'b0);
    build_expected(0);
    compare_lists("frame after reset with pending sample");

    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 3; k++) begin
        run_frame(d, 2, 2, (k == 1));
        build_expected(d);
        compare_lists($sformatf("random dut%0d frame%0d", d, k));
        check("random sample count vs grid size", obs_row.size(),
              ((cfg_r(d) - KD) / cfg_s(d) + 1) * ((cfg_r(d) - KD) / cfg_s(d) + 1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pool_window_ctrl.md
# pool_window_ctrl

Frame-level sequencer for the max-pooling sliding-window datapath. Accepts a raster pixel stream under valid/ready handshake and forwards it to the sliding window as explicit shift strobes. Tracks row/column position and flags exactly the window positions that are legal pooling outputs for the configured stride. Holds each flagged position until the downstream max unit accepts it, back-pressuring the input meanwhile.

## Interface
- DATA_WIDTH, 8, pixel width
- KERNEL_DIM, 3, window edge; must satisfy 1 <= KERNEL_DIM <= ROW_SIZE
- ROW_SIZE, 5, frame edge (square frame, ROW_SIZE*ROW_SIZE pixels)
- STRIDE, 1, pooling stride; must be >= 1
- OUT_DIM (localparam), (ROW_SIZE-KERNEL_DIM)/STRIDE+1, output grid edge
- CW (localparam), $clog2(ROW_SIZE), counter width
---
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE
- busy  out  1  high from the cycle after start until DONE inclusive
- done  out  1  one-cycle pulse at frame end
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  controller accepts pixel this cycle
- in_pixel  in  DATA_WIDTH  upstream pixel
- win_clear  out  1  clears sliding-window buffer contents
- win_shift  out  1  sliding window registers win_pixel this edge
- win_pixel  out  DATA_WIDTH  pixel to sliding window, combinational copy of in_pixel
- sample_valid  out  1  sliding-window output is a legal pooling position
- sample_ready  in  1  max unit consumes the window
- out_row, out_col  out  CW  output-grid coordinates of the pending sample

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE → CLEAR on start. CLEAR lasts one cycle with win_clear=1, then goes to STREAM. Counters row/col and stride phases are zeroed here.
- STREAM: in_ready = !sample_valid || sample_ready.
  - accept = in_valid && in_ready.
  - win_shift = accept. No shift ever occurs outside STREAM.
- On accept of pixel (r,c):
  - col advances and wraps at ROW_SIZE-1, incrementing row.
  - Sample position iff r>=KERNEL_DIM-1, c>=KERNEL_DIM-1, (r-KERNEL_DIM+1)%STRIDE==0 and (c-KERNEL_DIM+1)%STRIDE==0.
  - Modulo is implemented with phase counters; no dividers.
  - On a sample position, sample_valid is set next cycle, with out_row=(r-KERNEL_DIM+1)/STRIDE and out_col likewise.
- sample_valid is held, with coordinates stable, until sample_ready. It clears on handshake unless a new sample is set the same edge.
- Accept of pixel (ROW_SIZE-1, ROW_SIZE-1) → DRAIN.
- DRAIN → DONE when sample_valid==0 or on a sample handshake.
- DONE: done=1 for one cycle, then → IDLE.
- start outside IDLE is ignored.
- Samples per frame are exactly OUT_DIM². The last pixel is a sample only when (ROW_SIZE-KERNEL_DIM)%STRIDE==0.
- rst at any time: → IDLE, counters zero, no completion pulse.

## Timing
- Reset values: busy, done, in_ready, win_clear, win_shift, sample_valid = 0; out_row = out_col = 0; win_pixel follows in_pixel.
- Latency: sample_valid rises one cycle after the accepting edge of its pixel, matching the sliding window's one-cycle register.
- Full rate: one pixel per cycle while sample_ready=1.
- done rises exactly 2 cycles after the last accept when sample_ready=1.
- Simultaneous sample handshake and accept is permitted. The window changes only after it was consumed.
- in_ready is combinational from sample_valid/sample_ready. in_valid does not depend on in_ready.

## Structure
- Package pool_pkg:
  - state enum pool_state_t
  - function out_dim(row, k, stride)
  - parameter-legality assertions
- Sub-module pool_pos_counter: col/row counters with wrap, stride phase counters, out_row/out_col generation, and the is_sample/is_last flags.
- Top: FSM plus sample_valid hold register.
- The sliding window is instantiated by the parent and driven by win_clear/win_shift/win_pixel.

## Test plan
- Defaults, pixels 1..25 back-to-back, sample_ready=1:
  - 9 samples, one cycle after accepting pixels 13,14,15,18,19,20,23,24,25.
  - First sample has out_row=0, out_col=0.
  - done pulses 2 cycles after pixel 25.
- STRIDE=2, same stream: 4 samples after pixels 13,15,23,25, with coordinates (0,0),(0,1),(1,0),(1,1).
- sample_ready low 3 cycles at first sample:
  - in_ready=0 and win_shift=0 for those cycles.
  - Pixel 14 is accepted on the release cycle.
  - Sample count is still 9.
- ROW_SIZE=6, KERNEL_DIM=3, STRIDE=2:
  - 4 samples.
  - Pixel 36 produces no sample.
  - done follows 2 cycles after pixel 36.
- in_valid toggled 1/0 every cycle:
  - Same 9 samples in order.
  - win_shift pulses only on accepts.
- rst asserted after pixel 10:
  - Next cycle all outputs are at reset values.
  - A new start then produces the full 9-sample frame.
  - start pulsed mid-frame has no effect.
